// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the Hack word serializer and its serial helpers.
package word_serializer_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned WORD_CNT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

    // Counter width for a frame of w bits, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/word_serializer_bit_counter.sv
// Up-counter with synchronous clear (priority) and enable; shared by serial TX/RX blocks.
module bit_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/word_serializer.sv
// Parallel-in, MSB-first serial-out transmitter with valid/last framing.
// Optional trailing even-parity bit enabled by defining WORD_SERIALIZER_PARITY_EN.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last
);

    localparam int unsigned      CNT_W      = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_clr;
    logic             cnt_en;
    logic             ready_q, ready_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             last_q, last_d;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    bit_counter #(
        .W (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt_q)
    );

    // Next state, datapath and next-cycle output decode.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    shreg_d = in;
                    cnt_clr = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
                    parity_d = ^in;
`endif
                end
            end
            SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                // Hold at the final count so the counter never wraps.
                cnt_en  = (cnt_q != CNT_LAST);
                if (cnt_q == CNT_LAST) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            PARITY: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d      = (state_d == IDLE);
        sout_valid_d = (state_d != IDLE);
        sout_d       = (state_d == SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
        if (state_d == PARITY) begin
            sout_d = parity_d;
        end
        last_d = (state_d == PARITY);
`else
        // Next cycle carries bit 0 when the counter is about to reach WIDTH-1.
        last_d = (state_q == SHIFT) && (state_d == SHIFT) && (cnt_q == CNT_PENULT);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            ready_q      <= 1'b1;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            last_q       <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            ready_q      <= ready_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            last_q       <= last_d;
`ifdef WORD_SERIALIZER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign ready      = ready_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign last       = last_q;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer against a frame-level reference model.
module tb_word_serializer;

    localparam int unsigned W = 16;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int unsigned FLEN = W + 1;
`else
    localparam int unsigned FLEN = W;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] in_w  = '0;
    logic         ready;
    logic         sout;
    logic         sout_valid;
    logic         last;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] got_vec;
    logic [31:0] got_lmask;
    int          got_n;
    int          ready_bad;
    bit          cap_timeout;

    word_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .in         (in_w),
        .ready      (ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .last       (last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected frame: word bits MSB first, then optional even parity, packed LSB-last.
    function automatic logic [31:0] model_vec(input logic [W-1:0] w);
        bit          q[$];
        int          ones = 0;
        logic [31:0] v    = '0;
        for (int i = W - 1; i >= 0; i--) begin
            q.push_back(w[i]);
            ones += int'(w[i]);
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        q.push_back(ones % 2 == 1);
`endif
        foreach (q[k]) v = {v[30:0], q[k]};
        return v;
    endfunction

    // Called at a negedge while ready; leaves us at the negedge showing the first bit.
    task automatic start_frame(input logic [W-1:0] w);
        load = 1'b1;
        in_w = w;
        @(negedge clk);
        load = 1'b0;
        in_w = W'($urandom);
    endtask

    // Records valid bits until sout_valid drops; optionally pokes load mid-frame or holds it.
    task automatic capture(input int inject_at, input bit hold, input logic [W-1:0] hold_word);
        got_vec     = '0;
        got_lmask   = '0;
        got_n       = 0;
        ready_bad   = 0;
        cap_timeout = 1'b1;
        for (int c = 0; c < int'(FLEN) + 8; c++) begin
            if (!sout_valid) begin
                cap_timeout = 1'b0;
                break;
            end
            got_vec   = {got_vec[30:0], sout};
            got_lmask = {got_lmask[30:0], last};
            got_n++;
            if (ready) ready_bad++;
            if (hold) begin
                load = 1'b1;
                in_w = hold_word;
            end else if (c == inject_at) begin
                load = 1'b1;
                in_w = 16'd11111;
            end else begin
                load = 1'b0;
                in_w = W'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({ready, sout, sout_valid, last} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 1000", {ready, sout, sout_valid, last});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (ready !== 1'b1 || sout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b valid=%b expected ready=1 valid=0", ready, sout_valid);
        end
    endtask

    task automatic test_single_frame();
        logic [W-1:0] w = 16'h8285;
        start_frame(w);
        capture(-1, 1'b0, '0);
        vectors++;
        if (got_n !== int'(FLEN) || cap_timeout) begin
            miscompares++;
            $display("FAIL single_len: got %0d bits (timeout=%0d) expected %0d", got_n, cap_timeout, FLEN);
        end
        vectors++;
        if (got_vec !== model_vec(w)) begin
            miscompares++;
            $display("FAIL single_bits: got %h expected %h", got_vec, model_vec(w));
        end
        vectors++;
        if (got_lmask !== 32'd1) begin
            miscompares++;
            $display("FAIL single_last: got mask %h expected 00000001", got_lmask);
        end
        vectors++;
        if (ready !== 1'b1 || ready_bad != 0) begin
            miscompares++;
            $display("FAIL single_ready: ready=%b busy_ready_cycles=%0d expected 1/0", ready, ready_bad);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            logic [W-1:0] w = W'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_frame(w);
            capture(-1, 1'b0, '0);
            vectors++;
            if (got_n !== int'(FLEN) || got_vec !== model_vec(w) || got_lmask !== 32'd1) begin
                miscompares++;
                $display("FAIL random_frame: word %h got n=%0d bits=%h last=%h expected n=%0d bits=%h last=1",
                         w, got_n, got_vec, got_lmask, FLEN, model_vec(w));
            end
        end
    endtask

    task automatic test_ignored_load();
        logic [W-1:0] w = W'($urandom);
        start_frame(w);
        capture(4, 1'b0, '0);
        vectors++;
        if (got_n !== int'(FLEN) || got_vec !== model_vec(w) || got_lmask !== 32'd1) begin
            miscompares++;
            $display("FAIL ignored_frame: got n=%0d bits=%h last=%h expected n=%0d bits=%h",
                     got_n, got_vec, got_lmask, FLEN, model_vec(w));
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (sout_valid !== 1'b0 || ready !== 1'b1) begin
                miscompares++;
                $display("FAIL ignored_no_second: cycle %0d valid=%b ready=%b expected 0/1", i, sout_valid, ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w = 16'h2B67;
        start_frame(w);
        load = 1'b1;
        in_w = w;
        for (int f = 0; f < 3; f++) begin
            capture(-1, 1'b1, w);
            vectors++;
            if (got_n !== int'(FLEN) || got_vec !== model_vec(w) || got_lmask !== 32'd1) begin
                miscompares++;
                $display("FAIL b2b_frame%0d: got n=%0d bits=%h last=%h expected n=%0d bits=%h",
                         f, got_n, got_vec, got_lmask, FLEN, model_vec(w));
            end
            vectors++;
            if (ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_gap_ready%0d: got %b expected 1", f, ready);
            end
            if (f == 2) load = 1'b0;
            @(negedge clk);
            vectors++;
            if (sout_valid !== (f != 2)) begin
                miscompares++;
                $display("FAIL b2b_gap_len%0d: valid after one idle cycle=%b expected %b", f, sout_valid, f != 2);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] w1 = W'($urandom);
        logic [W-1:0] w2 = W'($urandom);
        int saw_last = 0;
        start_frame(w1);
        for (int i = 0; i < 7; i++) begin
            if (last) saw_last++;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ready, sout, sout_valid, last} !== 4'b1000 || saw_last != 0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %b last_seen=%0d expected 1000 and 0",
                     {ready, sout, sout_valid, last}, saw_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame(w2);
        capture(-1, 1'b0, '0);
        vectors++;
        if (got_n !== int'(FLEN) || got_vec !== model_vec(w2) || got_lmask !== 32'd1) begin
            miscompares++;
            $display("FAIL midreset_fresh: got n=%0d bits=%h last=%h expected n=%0d bits=%h",
                     got_n, got_vec, got_lmask, FLEN, model_vec(w2));
        end
    endtask

`ifdef WORD_SERIALIZER_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] words [2] = '{16'h8285, 16'h0000};
        logic         pbit  [2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            start_frame(words[k]);
            capture(-1, 1'b0, '0);
            vectors++;
            if (got_n !== 17 || got_vec[0] !== pbit[k] || got_lmask !== 32'd1) begin
                miscompares++;
                $display("FAIL parity_bit%0d: n=%0d bit=%b last=%h expected 17/%b/1",
                         k, got_n, got_vec[0], got_lmask, pbit[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_random_frames();
        test_ignored_load();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef WORD_SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
